// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS memory-access stage with MEM/WB register and data memory
// Optional misaligned-access detection enabled by macro DMEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        we_control,
    input  logic        mem_control_rd,
    input  logic        mem_control_wr,
    input  logic [31:0] add_branch,
    input  logic        zero,
    input  logic [31:0] result,
    input  logic [31:0] write_data,
    input  logic [4:0]  reg_dst,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        we_control_out,
    output logic        mem_to_reg_out,
    output logic [31:0] read_data_out,
    output logic [31:0] result_out,
    output logic [4:0]  reg_dst_out,
    output logic        align_err
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              misaligned;
    logic              store_en;
    logic [31:0]       load_word;

    assign pc_src        = branch & zero;
    assign branch_target = add_branch;
    assign addr          = result[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (result[1:0] != 2'b00) && (mem_control_rd || mem_control_wr);
`else
    assign misaligned = 1'b0;
`endif

    assign store_en  = mem_control_wr & ~stall & ~misaligned;
    // Read path sees the pre-edge contents, giving read-before-write on collisions.
    assign load_word = (mem_control_rd & ~misaligned) ? mem[addr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_en) begin
            mem[addr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_control_out <= 1'b0;
            mem_to_reg_out <= 1'b0;
            read_data_out  <= 32'h0;
            result_out     <= 32'h0;
            reg_dst_out    <= 5'd0;
        end else if (!stall) begin
            we_control_out <= we_control;
            mem_to_reg_out <= mem_control_rd;
            read_data_out  <= load_word;
            result_out     <= result;
            reg_dst_out    <= reg_dst;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err <= 1'b0;
        end else if (!stall && misaligned) begin
            align_err <= 1'b1;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed plus randomized bench for mem_wb_stage against a word-array model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        we_control = 1'b0;
    logic        mem_control_rd = 1'b0;
    logic        mem_control_wr = 1'b0;
    logic [31:0] add_branch = 32'h0;
    logic        zero = 1'b0;
    logic [31:0] result = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [4:0]  reg_dst = 5'd0;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        we_control_out;
    logic        mem_to_reg_out;
    logic [31:0] read_data_out;
    logic [31:0] result_out;
    logic [4:0]  reg_dst_out;
    logic        align_err;

    int errors = 0;
    int checks = 0;

    // Reference state: a plain word array plus the expected MEM/WB contents.
    logic [31:0] m_mem [256];
    logic        e_we;
    logic        e_m2r;
    logic [31:0] e_rd;
    logic [31:0] e_res;
    logic [4:0]  e_rdst;
    logic        e_align;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    mem_wb_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch),
        .we_control(we_control), .mem_control_rd(mem_control_rd),
        .mem_control_wr(mem_control_wr), .add_branch(add_branch), .zero(zero),
        .result(result), .write_data(write_data), .reg_dst(reg_dst),
        .pc_src(pc_src), .branch_target(branch_target),
        .we_control_out(we_control_out), .mem_to_reg_out(mem_to_reg_out),
        .read_data_out(read_data_out), .result_out(result_out),
        .reg_dst_out(reg_dst_out), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        e_we = 0; e_m2r = 0; e_rd = 0; e_res = 0; e_rdst = 0; e_align = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".we"},    {31'h0, we_control_out}, {31'h0, e_we});
        chk({tag, ".m2r"},   {31'h0, mem_to_reg_out}, {31'h0, e_m2r});
        chk({tag, ".rdata"}, read_data_out, e_rd);
        chk({tag, ".res"},   result_out, e_res);
        chk({tag, ".rdst"},  {27'h0, reg_dst_out}, {27'h0, e_rdst});
        chk({tag, ".align"}, {31'h0, align_err}, {31'h0, e_align});
    endtask

    // Applies one cycle of inputs, checks combinational outputs, clocks, checks registers.
    task automatic cyc(input string tag, input bit st, input bit br, input bit z,
                       input bit we, input bit rd, input bit wr,
                       input logic [31:0] ab, input logic [31:0] res,
                       input logic [31:0] wd, input logic [4:0] rdst);
        int  a;
        bit  mis;
        stall = st; branch = br; zero = z; we_control = we;
        mem_control_rd = rd; mem_control_wr = wr; add_branch = ab;
        result = res; write_data = wd; reg_dst = rdst;
        #1;
        chk({tag, ".pc_src"}, {31'h0, pc_src}, {31'h0, (br && z)});
        chk({tag, ".target"}, branch_target, ab);
        if (!st) begin
            a   = int'((res / 4) % 256);
            mis = ALIGN_EN && (res % 4 != 0) && (rd || wr);
            e_rd = (rd && !mis) ? m_mem[a] : 32'h0;
            if (wr && !mis) m_mem[a] = wd;
            e_we = we; e_m2r = rd; e_res = res; e_rdst = rdst;
            if (mis) e_align = 1'b1;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input string tag, input bit st);
        stall = st; we_control = 1; mem_control_rd = 1; mem_control_wr = 1;
        result = 32'h10; write_data = 32'hFFFF_FFFF; reg_dst = 5'd31;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_regs(tag);
        @(posedge clk);
        #1;
        check_regs({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        model_clear();
        @(posedge clk);
        #1;
        do_reset("reset", 1'b0);

        // Loads after reset return zero everywhere.
        cyc("rst_ld0", 0, 0, 0, 1, 1, 0, 0, 32'h0000_0000, 0, 5'd1);
        cyc("rst_ld1", 0, 0, 0, 1, 1, 0, 0, 32'h0000_03FC, 0, 5'd2);

        // Store then load.
        cyc("st",   0, 0, 0, 0, 0, 1, 0, 32'h10, 32'hDEAD_BEEF, 5'd0);
        cyc("ld",   0, 0, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd3);
        chk("ld.direct", read_data_out, 32'hDEAD_BEEF);

        // Read-before-write on the same word.
        cyc("rbw_init", 0, 0, 0, 0, 0, 1, 0, 32'h10, 32'h1111, 5'd0);
        cyc("rbw",      0, 0, 0, 1, 1, 1, 0, 32'h10, 32'h2222, 5'd4);
        chk("rbw.old", read_data_out, 32'h1111);
        cyc("rbw_new",  0, 0, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd4);
        chk("rbw.new", read_data_out, 32'h2222);

        // Stall holds outputs and suppresses the store.
        cyc("stl_cap", 0, 0, 0, 1, 0, 0, 0, 32'h44, 32'h0, 5'd7);
        cyc("stl",     1, 0, 0, 1, 0, 1, 0, 32'h20, 32'h5555, 5'd9);
        chk("stl.rdst", {27'h0, reg_dst_out}, 32'd7);
        cyc("stl_ld",  0, 0, 0, 1, 1, 0, 0, 32'h20, 32'h0, 5'd9);
        chk("stl.mem", read_data_out, 32'h0);

        // Branch resolution and address wrap.
        cyc("br_t",  0, 1, 1, 0, 0, 0, 32'h400, 32'h0, 0, 5'd0);
        cyc("br_nt", 0, 1, 0, 0, 0, 0, 32'h400, 32'h0, 0, 5'd0);
        cyc("wrap_st", 0, 0, 0, 0, 0, 1, 0, 32'h400, 32'hCAFE_F00D, 5'd0);
        cyc("wrap_ld", 0, 0, 0, 1, 1, 0, 0, 32'h0, 32'h0, 5'd5);
        chk("wrap.word0", read_data_out, 32'hCAFE_F00D);

        // Misaligned store: suppressed with the check enabled, word access without it.
        cyc("mis_st", 0, 0, 0, 0, 0, 1, 0, 32'h13, 32'hABCD_0123, 5'd0);
        cyc("mis_ld", 0, 0, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd6);
        cyc("mis_hold", 0, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0, 5'd0);

        // Randomized traffic on a small window of words, with stalls and a mid-stall reset.
        for (int i = 0; i < 300; i++) begin
            r = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
                | (($urandom_range(0, 3) == 0) ? ($urandom & 32'h3) : 32'h0);
            if (i == 150) do_reset("rnd_reset", 1'b1);
            cyc("rnd", ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom, r, $urandom, 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
